minc_core: RTL and testbench



---
 rtl/minc_pkg.sv | 30 +++
 rtl/minc_stack.sv | 66 ++++++
 rtl/minc_core.sv | 148 ++++++++++++++
 tb/tb_minc_core.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/minc_pkg.sv
// Shared opcodes, FSM states and fault codes for the minc stack-machine core.
package minc_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned FC_W = 2;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_PUSH = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_W-1:0] OP_MUL  = 4'h4;
  localparam logic [OP_W-1:0] OP_DUP  = 4'h5;
  localparam logic [OP_W-1:0] OP_DROP = 4'h6;
  localparam logic [OP_W-1:0] OP_SWAP = 4'h7;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h8;
  localparam logic [OP_W-1:0] OP_JZ   = 4'h9;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [FC_W-1:0] FC_NONE = 2'b00;
  localparam logic [FC_W-1:0] FC_OVF  = 2'b01;
  localparam logic [FC_W-1:0] FC_UNF  = 2'b10;
  localparam logic [FC_W-1:0] FC_ILL  = 2'b11;

endpackage

// File: rtl/minc_stack.sv
// LIFO register file with stack pointer; pops/pushes/writes apply only on commit.
module minc_stack #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SP_W   = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              commit_i,
  input  logic [1:0]        need_i,
  input  logic [1:0]        pop_i,
  input  logic              push_i,
  input  logic              wr_t_en_i,
  input  logic [DATA_W-1:0] wr_t_i,
  input  logic              wr_n_en_i,
  input  logic [DATA_W-1:0] wr_n_i,
  output logic [DATA_W-1:0] t_c,
  output logic [DATA_W-1:0] n_c,
  output logic [SP_W-1:0]   sp_o,
  output logic              unf_c,
  output logic              ovf_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;
  logic [SP_W-1:0]   sp_new;
  logic [SP_W:0]     sp_ext;

  // Resulting depth and range checks; the extra bit catches both wrap directions.
  always_comb begin
    sp_ext = {1'b0, sp_q} - (SP_W+1)'(pop_i) + (SP_W+1)'(push_i);
    sp_new = sp_ext[SP_W-1:0];
    unf_c  = sp_q < SP_W'(need_i);
    ovf_c  = sp_ext > (SP_W+1)'(DEPTH);
    sp_d   = commit_i ? sp_new : sp_q;
  end

  // Top two entries, zero when not present.
  always_comb begin
    t_c = '0;
    n_c = '0;
    if (sp_q >= SP_W'(1)) t_c = mem_q[AW'(sp_q - SP_W'(1))];
    if (sp_q >= SP_W'(2)) n_c = mem_q[AW'(sp_q - SP_W'(2))];
  end

  // Stack pointer register.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) sp_q <= '0;
    else         sp_q <= sp_d;
  end

  // Slot writes relative to the post-op pointer; anything landing during reset sits above sp=0
  // and is always rewritten by a push before it can be read.
  always_ff @(posedge CLK) begin
    if (commit_i) begin
      if (wr_t_en_i) mem_q[AW'(sp_new - SP_W'(1))] <= wr_t_i;
      if (wr_n_en_i) mem_q[AW'(sp_new - SP_W'(2))] <= wr_n_i;
    end
  end

  assign sp_o = sp_q;

endmodule

// File: rtl/minc_core.sv
// minc stack-machine core: fetch from async ROM, decode, ALU, pc and RUN/HALT/FAULT control.
module minc_core
  import minc_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned PC_W   = 8,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned SP_W   = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic                 en,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [OP_W+DATA_W-1:0] imem_data,
  output logic [PC_W-1:0]      pc_out,
  output logic [DATA_W-1:0]    top_out,
  output logic [SP_W-1:0]      sp_out,
  output logic                 halted,
  output logic                 fault,
  output logic [FC_W-1:0]      fault_code
);

  if (PC_W > DATA_W) begin : g_pc_w_check
    $error("minc_core: PC_W must not exceed DATA_W");
  end

  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   pc_q, pc_d, pc_nxt;
  state_e            state_q, state_d;
  logic [FC_W-1:0]   fc_q, fc_d;

  logic [DATA_W-1:0] t_c, n_c;
  logic [1:0]        need, pop;
  logic              push, wr_t_en, wr_n_en;
  logic [DATA_W-1:0] wr_t, wr_n;
  logic              illegal, is_halt, unf_c, ovf_c;
  logic              active, fault_c, commit;
  logic [FC_W-1:0]   code_c;

  assign op  = imem_data[OP_W+DATA_W-1:DATA_W];
  assign imm = imem_data[DATA_W-1:0];

  // Instruction decode and ALU.
  always_comb begin
    need    = 2'd0;
    pop     = 2'd0;
    push    = 1'b0;
    wr_t_en = 1'b0;
    wr_t    = '0;
    wr_n_en = 1'b0;
    wr_n    = '0;
    illegal = 1'b0;
    is_halt = 1'b0;
    pc_nxt  = pc_q + PC_W'(1);
    case (op)
      OP_NOP:  ;
      OP_PUSH: begin push = 1'b1; wr_t_en = 1'b1; wr_t = imm; end
      OP_ADD:  begin need = 2'd2; pop = 2'd2; push = 1'b1; wr_t_en = 1'b1; wr_t = t_c + n_c; end
      OP_SUB:  begin need = 2'd2; pop = 2'd2; push = 1'b1; wr_t_en = 1'b1; wr_t = t_c - n_c; end
      OP_MUL:  begin need = 2'd2; pop = 2'd2; push = 1'b1; wr_t_en = 1'b1; wr_t = t_c * n_c; end
      OP_DUP:  begin need = 2'd1; push = 1'b1; wr_t_en = 1'b1; wr_t = t_c; end
      OP_DROP: begin need = 2'd1; pop = 2'd1; end
      OP_SWAP: begin
        need    = 2'd2;
        wr_t_en = 1'b1;
        wr_t    = n_c;
        wr_n_en = 1'b1;
        wr_n    = t_c;
      end
      OP_JMP:  pc_nxt = imm[PC_W-1:0];
      OP_JZ:   begin
        need = 2'd1;
        pop  = 2'd1;
        if (t_c == '0) pc_nxt = imm[PC_W-1:0];
      end
      OP_HALT: begin is_halt = 1'b1; pc_nxt = pc_q; end
      default: illegal = 1'b1;
    endcase
  end

  // Fault resolution: illegal beats underflow beats overflow.
  always_comb begin
    fault_c = illegal | unf_c | ovf_c;
    code_c  = illegal ? FC_ILL : (unf_c ? FC_UNF : (ovf_c ? FC_OVF : FC_NONE));
    active  = en && (state_q == ST_RUN);
    commit  = active && !fault_c && !is_halt;
  end

  minc_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .SP_W   (SP_W)
  ) u_stack (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .commit_i  (commit),
    .need_i    (need),
    .pop_i     (pop),
    .push_i    (push),
    .wr_t_en_i (wr_t_en),
    .wr_t_i    (wr_t),
    .wr_n_en_i (wr_n_en),
    .wr_n_i    (wr_n),
    .t_c       (t_c),
    .n_c       (n_c),
    .sp_o      (sp_out),
    .unf_c     (unf_c),
    .ovf_c     (ovf_c)
  );

  // Control state, pc and fault-code registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fc_q    <= fc_d;
    end
  end

  // Next state: a faulting instruction only latches the code; HALT and FAULT are sticky.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fc_d    = fc_q;
    if (active) begin
      if (fault_c) begin
        state_d = ST_FAULT;
        fc_d    = code_c;
      end else begin
        pc_d = pc_nxt;
        if (is_halt) state_d = ST_HALT;
      end
    end
  end

  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign top_out    = t_c;
  assign halted     = (state_q == ST_HALT);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fc_q;

endmodule

// File: tb/tb_minc_core.sv
// Directed self-checking bench for minc_core (DEPTH=4 instance).
module tb_minc_core;
  import minc_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned PW  = 8;
  localparam int unsigned DEP = 4;
  localparam int unsigned SPW = $clog2(DEP + 1);

  logic             CLK = 1'b0;
  logic             nRESET;
  logic             en;
  logic [PW-1:0]    imem_addr;
  logic [DW+3:0]    imem_data;
  logic [PW-1:0]    pc_out;
  logic [DW-1:0]    top_out;
  logic [SPW-1:0]   sp_out;
  logic             halted;
  logic             fault;
  logic [1:0]       fault_code;

  logic [DW+3:0]    rom [256];
  int               tests;
  int               fails;
  int               cyc;

  minc_core #(.DATA_W(DW), .PC_W(PW), .DEPTH(DEP)) dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .en         (en),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .pc_out     (pc_out),
    .top_out    (top_out),
    .sp_out     (sp_out),
    .halted     (halted),
    .fault      (fault),
    .fault_code (fault_code)
  );

  assign imem_data = rom[imem_addr];

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW+3:0] ins(input logic [3:0] op, input logic [DW-1:0] imm);
    return {op, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(OP_HALT, 8'd0);
  endtask

  task automatic reset_dut();
    en     = 1'b0;
    nRESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk_state(input string tag, input int pc, input int sp, input int top,
                           input int h, input int f, input int fc);
    chk({tag, "_pc"},  32'(pc_out),     32'(pc));
    chk({tag, "_sp"},  32'(sp_out),     32'(sp));
    chk({tag, "_top"}, 32'(top_out),    32'(top));
    chk({tag, "_hlt"}, 32'(halted),     32'(h));
    chk({tag, "_flt"}, 32'(fault),      32'(f));
    chk({tag, "_fc"},  32'(fault_code), 32'(fc));
  endtask

  task automatic load_prog1();
    clear_rom();
    rom[0] = ins(OP_PUSH, 8'd3);
    rom[1] = ins(OP_PUSH, 8'd5);
    rom[2] = ins(OP_SUB,  8'd0);
    rom[3] = ins(OP_HALT, 8'd0);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    nRESET = 1'b0;
    en     = 1'b0;

    // Test 1: PUSH 3, PUSH 5, SUB, HALT
    load_prog1();
    reset_dut();
    chk_state("t1_rst", 0, 0, 0, 0, 0, 0);
    chk("t1_imem_addr", 32'(imem_addr), 0);
    en = 1'b1;
    step(1); chk_state("t1_push3", 1, 1, 3, 0, 0, 0);
    step(1); chk_state("t1_push5", 2, 2, 5, 0, 0, 0);
    step(1); chk_state("t1_sub",   3, 1, 2, 0, 0, 0);
    step(1); chk_state("t1_halt",  3, 1, 2, 1, 0, 0);
    step(10); chk_state("t1_held", 3, 1, 2, 1, 0, 0);

    // Test 2: overflow on fifth push into a 4-deep stack
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = ins(OP_PUSH, 8'd1);
    reset_dut();
    en = 1'b1;
    step(4); chk_state("t2_full", 4, 4, 1, 0, 0, 0);
    step(1); chk_state("t2_ovf",  4, 4, 1, 0, 1, 1);
    step(3); chk_state("t2_hold", 4, 4, 1, 0, 1, 1);

    // Test 3: underflow on ADD with a single entry
    clear_rom();
    rom[0] = ins(OP_PUSH, 8'd7);
    rom[1] = ins(OP_ADD,  8'd0);
    reset_dut();
    chk_state("t3_rst", 0, 0, 0, 0, 0, 0);
    en = 1'b1;
    step(1); chk_state("t3_push", 1, 1, 7, 0, 0, 0);
    step(1); chk_state("t3_unf",  1, 1, 7, 0, 1, 2);

    // Test 4a: countdown loop using DUP/JZ/PUSH/SWAP/SUB/JMP
    clear_rom();
    rom[0] = ins(OP_PUSH, 8'd3);
    rom[1] = ins(OP_DUP,  8'd0);
    rom[2] = ins(OP_JZ,   8'd7);
    rom[3] = ins(OP_PUSH, 8'd1);
    rom[4] = ins(OP_SWAP, 8'd0);
    rom[5] = ins(OP_SUB,  8'd0);
    rom[6] = ins(OP_JMP,  8'd1);
    rom[7] = ins(OP_HALT, 8'd0);
    reset_dut();
    en  = 1'b1;
    cyc = 0;
    while (!halted && cyc < 200) begin
      step(1);
      cyc++;
    end
    chk("t4_loop_cycles", 32'(cyc), 22);
    chk_state("t4_loop_end", 7, 1, 0, 1, 0, 0);

    // Test 4b: wrapping ADD and MUL, then DROP
    clear_rom();
    rom[0] = ins(OP_PUSH, 8'd200);
    rom[1] = ins(OP_PUSH, 8'd100);
    rom[2] = ins(OP_ADD,  8'd0);
    rom[3] = ins(OP_PUSH, 8'd16);
    rom[4] = ins(OP_PUSH, 8'd16);
    rom[5] = ins(OP_MUL,  8'd0);
    rom[6] = ins(OP_DROP, 8'd0);
    rom[7] = ins(OP_HALT, 8'd0);
    reset_dut();
    en = 1'b1;
    step(3); chk_state("t4_add", 3, 1, 44, 0, 0, 0);
    step(3); chk_state("t4_mul", 6, 2, 0, 0, 0, 0);
    step(1); chk_state("t4_drop", 7, 1, 44, 0, 0, 0);
    step(1); chk_state("t4_halt", 7, 1, 44, 1, 0, 0);

    // Test 5: enable gating and illegal opcode
    clear_rom();
    rom[0] = ins(OP_PUSH, 8'd1);
    rom[1] = ins(OP_PUSH, 8'd2);
    rom[2] = ins(OP_PUSH, 8'd3);
    rom[3] = ins(4'hB,    8'd0);
    reset_dut();
    en = 1'b1; step(1); chk_state("t5_en1a", 1, 1, 1, 0, 0, 0);
    en = 1'b0; step(1); chk_state("t5_en0a", 1, 1, 1, 0, 0, 0);
    step(1);            chk_state("t5_en0b", 1, 1, 1, 0, 0, 0);
    en = 1'b1; step(1); chk_state("t5_en1b", 2, 2, 2, 0, 0, 0);
    step(1);            chk_state("t5_push3", 3, 3, 3, 0, 0, 0);
    step(1);            chk_state("t5_ill", 3, 3, 3, 0, 1, 3);
    // Async reset out of FAULT clears it before any clock edge.
    #2 nRESET = 1'b0;
    #1 chk_state("t5_async_rst", 0, 0, 0, 0, 0, 0);

    // PC wrap from 255 to 0, with SWAP on the way
    clear_rom();
    rom[0]   = ins(OP_PUSH, 8'd5);
    rom[1]   = ins(OP_JMP,  8'd254);
    rom[254] = ins(OP_PUSH, 8'd9);
    rom[255] = ins(OP_SWAP, 8'd0);
    reset_dut();
    en = 1'b1;
    step(3); chk_state("tw_push9", 255, 2, 9, 0, 0, 0);
    step(1); chk_state("tw_wrap",  0, 2, 5, 0, 0, 0);

    // Test 6: reset pulsed mid-program, then a clean rerun of test 1
    load_prog1();
    reset_dut();
    en = 1'b1;
    step(2); chk_state("t6_pre", 2, 2, 5, 0, 0, 0);
    #2 nRESET = 1'b0;
    #1 chk_state("t6_async", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
    #1 chk_state("t6_rel", 0, 0, 0, 0, 0, 0);
    step(1); chk_state("t6_push3", 1, 1, 3, 0, 0, 0);
    step(3); chk_state("t6_halt",  3, 1, 2, 1, 0, 0);
    step(10); chk_state("t6_held", 3, 1, 2, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
